iomem_initiator: RTL and testbench



---
 rtl/iomem_initiator_pkg.sv | 17 +
 rtl/iomem_initiator.sv | 115 +++++++++++
 tb/tb_iomem_initiator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/iomem_initiator_pkg.sv
// Shared definitions for the iomem initiator: FSM state encodings,
// the read-command byte-enable value and the board GPIO base address.
package iomem_initiator_pkg;

    typedef enum logic [1:0] {
        IOM_IDLE = 2'd0,
        IOM_BUS  = 2'd1,
        IOM_RESP = 2'd2
    } iom_state_e;

    // A command with no byte enables set is a read.
    localparam logic [3:0] IOM_WSTRB_READ = 4'b0000;

    // Top address byte of the board-level GPIO register block.
    localparam logic [7:0] IOM_GPIO_BASE = 8'h03;

endpackage

// File: rtl/iomem_initiator.sv
// Bus-master end of the PicoSoC iomem interface. Takes one read/write
// command at a time, runs it on iomem with a cycle-count timeout and
// returns read data plus a timeout flag on the response port.
module iomem_initiator
    import iomem_initiator_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata
);

    // Counter value seen on the last cycle iomem_valid may stay high.
    // Only meaningful when the timeout is enabled (TIMEOUT != 0).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    iom_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Saturating increment so a disabled timeout never wraps the counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Commands are accepted only while idle; this is the one unregistered output.
    assign cmd_ready = (state == IOM_IDLE);

    // Transaction FSM: issue on iomem, wait for ready or timeout, hold response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IOM_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            iomem_valid <= 1'b0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wstrb <= '0;
        end else begin
            case (state)
                IOM_IDLE: begin
                    if (cmd_valid) begin
                        iomem_valid <= 1'b1;
                        iomem_addr  <= cmd_addr;
                        iomem_wdata <= cmd_wdata;
                        iomem_wstrb <= cmd_wstrb;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= IOM_BUS;
                    end
                end

                IOM_BUS: begin
                    // Request fields stay frozen here; only the counter moves.
                    cnt <= sat_inc(cnt);
                    if (iomem_ready) begin
                        // Ready wins even on the cycle the timeout would fire.
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= '0;
                        rsp_rdata   <= (iomem_wstrb == IOM_WSTRB_READ) ? iomem_rdata : 32'h0;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= IOM_RESP;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        iomem_valid <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= IOM_RESP;
                    end
                end

                IOM_RESP: begin
                    // rsp_rdata/rsp_err keep their values after the handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IOM_IDLE;
                    end
                end

                default: begin
                    rsp_valid   <= 1'b0;
                    iomem_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IOM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator with TIMEOUT=8: a 1-cycle GPIO
// responder model plus bench-driven ready pulses for boundary cases.
module tb_iomem_initiator;
    import iomem_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    // Responder: auto GPIO model (when enabled) OR a bench-driven pulse.
    logic        auto_en = 1'b1;
    logic        auto_rdy = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic [31:0] gpio_reg = '0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = '0;

    int nvec = 0;
    int nmis = 0;

    iomem_initiator #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
    );

    always #5 clk = ~clk;

    assign iomem_ready = (auto_en & auto_rdy) | man_ready;
    assign iomem_rdata = man_ready ? man_rdata : auto_rdata;

    // GPIO register at 0x03xx_xxxx answering one cycle after it sees valid.
    always @(posedge clk) begin
        if (auto_en && iomem_valid && !auto_rdy && iomem_addr[31:24] == IOM_GPIO_BASE) begin
            auto_rdy   <= 1'b1;
            auto_rdata <= gpio_reg;
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) gpio_reg[8*b +: 8] <= iomem_wdata[8*b +: 8];
        end else begin
            auto_rdy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ctl"}, {27'd0, cmd_ready, rsp_valid, rsp_err, busy, iomem_valid}, 32'b10000);
        check({pfx, "_rdata"}, rsp_rdata, 32'h0);
        check({pfx, "_addr"}, iomem_addr, 32'h0);
        check({pfx, "_wdata"}, iomem_wdata, 32'h0);
        check({pfx, "_wstrb"}, {28'd0, iomem_wstrb}, 32'h0);
    endtask

    // Issue one command; lat = cycle (relative to accept cycle N) where
    // rsp_valid first shows, vcnt = cycles iomem_valid was high.
    // ready_at > 0 makes the bench pulse iomem_ready in that cycle.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int ready_at, output int lat, output int vcnt);
        int bad;
        bad = 0;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 1; vcnt = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            man_ready = (lat == ready_at);
            man_rdata = 32'h1234_5678;
            if (iomem_valid === 1'b1) begin
                vcnt++;
                if (iomem_addr !== a || iomem_wdata !== wd || iomem_wstrb !== ws) bad++;
            end
            step();
            lat++;
        end
        man_ready = 1'b0;
        check("rsp_wait_bounded", {31'd0, lat < 40}, 32'd1);
        check("fields_stable", bad, 0);
        check("valid_low_in_resp", {31'd0, iomem_valid}, 32'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int lat, vcnt, seen;

        // Reset
        step(); step();
        check_reset_outputs("reset");
        resetn = 1'b1;
        step();

        // Write 0x1A5 with lane 0 enabled to GPIO
        run_cmd(32'h0300_0000, 32'h0000_01A5, 4'b0001, 0, lat, vcnt);
        check("wr_latency", lat, 3);
        check("wr_valid_cycles", vcnt, 2);
        check("wr_err", {31'd0, rsp_err}, 32'd0);
        check("wr_rdata", rsp_rdata, 32'h0);
        check("wr_busy", {31'd0, busy}, 32'd1);
        handshake();
        check("gpio_reg", gpio_reg, 32'h0000_00A5);

        // Read back
        run_cmd(32'h0300_0000, 32'h0, 4'b0000, 0, lat, vcnt);
        check("rd_latency", lat, 3);
        check("rd_rdata", rsp_rdata, 32'h0000_00A5);
        check("rd_err", {31'd0, rsp_err}, 32'd0);
        handshake();

        // Timeout with no responder, then backpressure with a stray ready
        auto_en = 1'b0;
        run_cmd(32'h0400_0010, 32'hCAFE_0001, 4'b1111, 0, lat, vcnt);
        check("to_valid_cycles", vcnt, 8);
        check("to_latency", lat, 9);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_rdata", rsp_rdata, 32'h0);
        for (int i = 0; i < 5; i++) begin
            man_ready = (i == 2);
            man_rdata = 32'hDEAD_BEEF;
            step();
            man_ready = 1'b0;
            check("bp_hold", {27'd0, rsp_valid, rsp_err, cmd_ready, iomem_valid, busy}, 32'b11001);
            check("bp_rdata", rsp_rdata, 32'h0);
        end
        handshake();
        man_ready = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        step();
        man_ready = 1'b0;
        step();
        check("idle_ready_ignored", {28'd0, rsp_valid, iomem_valid, busy, cmd_ready}, 32'b0001);
        check("idle_err_kept", {31'd0, rsp_err}, 32'd1);
        check("idle_rdata_kept", rsp_rdata, 32'h0);

        // Ready on the timeout boundary cycle (8th valid cycle = cycle N+8)
        run_cmd(32'h0500_0000, 32'h0, 4'b0000, 8, lat, vcnt);
        check("bnd_valid_cycles", vcnt, 8);
        check("bnd_latency", lat, 9);
        check("bnd_err", {31'd0, rsp_err}, 32'd0);
        check("bnd_rdata", rsp_rdata, 32'h1234_5678);
        handshake();

        // Reset while in BUS
        check("cmd_ready_pre_rst", {31'd0, cmd_ready}, 32'd1);
        cmd_addr = 32'h0600_0004; cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'b1010; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        check("mid_bus_valid", {31'd0, iomem_valid}, 32'd1);
        resetn = 1'b0;
        step();
        check_reset_outputs("mid_rst");
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid === 1'b1 || iomem_valid === 1'b1) seen++;
        end
        check("no_rsp_after_rst", seen, 0);

        // Fresh write after reset
        auto_en = 1'b1;
        run_cmd(32'h0300_0000, 32'h0000_005A, 4'b0001, 0, lat, vcnt);
        check("post_wr_latency", lat, 3);
        check("post_wr_rdata", rsp_rdata, 32'h0);
        check("post_wr_err", {31'd0, rsp_err}, 32'd0);
        handshake();
        check("post_gpio_reg", gpio_reg, 32'h0000_005A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

endmodule
